sha256d_nonce_scheduler: RTL and testbench
==========================================

# sha256d_nonce_scheduler

Controller that sequences the `sha256d_wrapper` core through a nonce sweep. It holds the 76 fixed bytes of a block header and serves the core's 32-bit word requests, inserting the current nonce as the last word. After each double hash it checks the result against a leading-zero-bits target, then advances the nonce or stops. It sits between the top-level host interface and the hash core and replaces per-hash host byte feeding with a single configured sweep.

## Interface
Parameters:
- HDR_BYTES, 76: fixed header bytes held locally (words 0..18).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- hdr_we  in  1  header byte write strobe; ignored while busy
- hdr_addr  in  7  header byte index 0..75; writes to larger indices are dropped
- hdr_wdata  in  8  header byte
- nonce_start  in  32  first nonce; sampled on go
- nonce_end  in  32  last nonce, inclusive; sampled on go
- zbits  in  9  required leading zero bits of the hash, 0..256; sampled on go
- go  in  1  start sweep; ignored while busy
- abort  in  1  stop the sweep after the in-flight hash
- busy  out  1  sweep active
- found  out  1  sticky: a hash met the target
- exhausted  out  1  sticky: range finished with no match
- aborted  out  1  sticky: sweep ended by abort
- found_nonce  out  32  nonce that met the target
- cur_nonce  out  32  nonce currently being hashed, or the last one hashed
- hash_count  out  32  hashes completed in this sweep (macro-gated)
- s_start  out  1  core start pulse
- s_rdy  out  1  core data-valid pulse
- s_data  out  32  word returned to the core
- s_addr  in  5  word index requested by the core
- s_rq  in  1  core word request
- s_hash  in  256  core result; valid while s_done is high
- s_done  in  1  core completion

## Operation
- Reset: every output is 0; state is IDLE; the header store is not reset.
- Word map: word k, for k = 0..18, is {hdr[4k], hdr[4k+1], hdr[4k+2], hdr[4k+3]}, with the first byte in the MSBs. Word 19 is the byte-swapped nonce {n[7:0], n[15:8], n[23:16], n[31:24]}. Any s_addr above 19 returns 0.
- IDLE: on go, latch nonce_start into cur_nonce, latch nonce_end and zbits, clear found, exhausted, aborted and hash_count, set busy, then enter LAUNCH.
- LAUNCH: drive s_start high for exactly one cycle, then enter SERVE.
- SERVE: when s_rq=1 and s_rdy=0, register s_data from s_addr and drive s_rdy=1 for one cycle. s_rdy is always low for at least one cycle between two pulses. On s_done, enter CHECK.
- CHECK, using the s_hash registered at s_done:
  - Match when zbits == 0, or when the top zbits bits of s_hash are all 0. zbits >= 256 requires an all-zero hash.
  - Increment hash_count.
  - If abort is pending: set aborted and go to IDLE.
  - Else if match: set found, set found_nonce = cur_nonce, go to IDLE.
  - Else if cur_nonce == nonce_end: set exhausted and go to IDLE.
  - Else: cur_nonce wraps modulo 2^32 (0xFFFFFFFF becomes 0), then go to LAUNCH.
- Priority within CHECK is abort, then match, then range end.
- busy clears on every entry to IDLE.
- abort: latched whenever busy and cleared on IDLE entry. The core is never abandoned mid-hash, so requests keep being served until s_done.
- nonce_end < nonce_start is legal and sweeps through the wrap.

## Timing
- go to s_start: 1 cycle (go sampled in cycle t, s_start high in cycle t+1).
- s_rq seen with s_rdy low in cycle t: s_rdy and s_data are valid in cycle t+1. s_data is held until the next request.
- s_done in cycle t: CHECK runs in t+1. The status bits update in t+2, or s_start for the next nonce is high in t+2.
- Simultaneous go and hdr_we in IDLE: the write is taken and the sweep uses the new byte.
- Reset mid-sweep forces IDLE immediately. The core shares rst_n and resets with it.

## Configuration
- SHA256D_SCHED_COUNT_EN defined: hash_count is a 32-bit saturating counter of completed hashes, cleared on go.
- SHA256D_SCHED_COUNT_EN undefined: hash_count is tied to 0 and no counter register exists.

## Structure
- Package sha256d_sched_pkg holds:
  - the state enum (IDLE, LAUNCH, SERVE, CHECK);
  - NONCE_WORD = 19;
  - HDR_WORDS = 20;
  - the localparam HDR_BYTES = 76.
- Sub-module sha256d_target_cmp: combinational compare that takes hash[255:0] and zbits[8:0] and outputs match.

## Test plan
- Header byte i = i, nonce range 0x12345678..0x12345678, zbits = 0 -> the core sees word0 = 0x00010203, word18 = 0x48494A4B and word19 = 0x78563412. Result: one hash, found = 1, found_nonce = 0x12345678, hash_count = 1.
- Range 0..2 with zbits = 256 against a behavioural core -> 3 s_start pulses, then exhausted = 1, cur_nonce = 2, hash_count = 3, busy = 0.
- Range 0xFFFFFFFE..0x00000001 with zbits = 256 -> 4 hashes on nonces FFFFFFFE, FFFFFFFF, 0, 1, then exhausted = 1.
- Model core returns the top 20 bits zero only for nonce 5; range 0..10 with zbits = 20 -> found_nonce = 5, hash_count = 6, and no further s_start.
- abort pulsed while 7 words are served -> all 20 words are still served and the s_done is consumed. Result: aborted = 1, found = 0, exhausted = 0.
- rst_n low during SERVE -> all outputs are 0 asynchronously. A later go restarts cleanly from nonce_start.

Source files
------------

// File: rtl/sha256d_sched_pkg.sv
// rtl/sha256d_sched_pkg.sv - shared states, word map constants and byte-swap helper for the nonce scheduler
package sha256d_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      SERVE,
      CHECK
   } sched_state_e;

   localparam int NONCE_WORD = 19;
   localparam int HDR_WORDS  = 20;
   localparam int HDR_BYTES  = 76;

   // The core expects the nonce word little-endian relative to cur_nonce
   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/sha256d_target_cmp.sv
// rtl/sha256d_target_cmp.sv - leading-zero-bits target compare; zbits >= 256 demands an all-zero hash
module sha256d_target_cmp (
   input  logic [255:0] hash,
   input  logic [8:0]   zbits,
   output logic         match
);

   // Bit i lies in the checked prefix when its distance from the MSB is below zbits
   always_comb begin
      match = 1'b1;
      for (int i = 0; i < 256; i++) begin
         if (((255 - i) < int'(zbits)) && hash[i]) begin
            match = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sha256d_nonce_scheduler.sv
// rtl/sha256d_nonce_scheduler.sv - sweeps nonces through the sha256d core and checks each result
// Optional saturating hash counter: SHA256D_SCHED_COUNT_EN
module sha256d_nonce_scheduler #(
   parameter int HDR_BYTES = 76
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hdr_we,
   input  logic [6:0]   hdr_addr,
   input  logic [7:0]   hdr_wdata,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic [8:0]   zbits,
   input  logic         go,
   input  logic         abort,
   output logic         busy,
   output logic         found,
   output logic         exhausted,
   output logic         aborted,
   output logic [31:0]  found_nonce,
   output logic [31:0]  cur_nonce,
   output logic [31:0]  hash_count,
   output logic         s_start,
   output logic         s_rdy,
   output logic [31:0]  s_data,
   input  logic [4:0]   s_addr,
   input  logic         s_rq,
   input  logic [255:0] s_hash,
   input  logic         s_done
);
   import sha256d_sched_pkg::*;

   sched_state_e  state_q, state_d;
   logic [7:0]    hdr_mem [HDR_BYTES];
   logic          found_q, found_d, exhausted_q, exhausted_d, aborted_q, aborted_d;
   logic          abort_q, abort_d, s_rdy_q, s_rdy_d;
   logic [31:0]   found_nonce_q, found_nonce_d, cur_nonce_q, cur_nonce_d;
   logic [31:0]   nonce_end_q, nonce_end_d, s_data_q, s_data_d;
   logic [8:0]    zbits_q, zbits_d;
   logic [255:0]  hash_q, hash_d;
   logic [31:0]   word_sel;
   logic          match;

   // Header bytes are configuration only, so the store carries no reset
   always_ff @(posedge clk) begin
      if (hdr_we && (state_q == IDLE) && (int'(hdr_addr) < HDR_BYTES)) begin
         hdr_mem[hdr_addr] <= hdr_wdata;
      end
   end

   always_comb begin
      word_sel = '0;
      if (s_addr < 5'(NONCE_WORD)) begin
         word_sel = {hdr_mem[{s_addr, 2'b00}], hdr_mem[{s_addr, 2'b01}],
                     hdr_mem[{s_addr, 2'b10}], hdr_mem[{s_addr, 2'b11}]};
      end else if (s_addr < 5'(HDR_WORDS)) begin
         word_sel = bswap32(cur_nonce_q);
      end
   end

   sha256d_target_cmp u_target_cmp (
      .hash  (hash_q),
      .zbits (zbits_q),
      .match (match)
   );

   always_comb begin
      state_d       = state_q;
      found_d       = found_q;
      exhausted_d   = exhausted_q;
      aborted_d     = aborted_q;
      found_nonce_d = found_nonce_q;
      cur_nonce_d   = cur_nonce_q;
      nonce_end_d   = nonce_end_q;
      zbits_d       = zbits_q;
      hash_d        = hash_q;
      s_data_d      = s_data_q;
      s_rdy_d       = 1'b0;
      abort_d       = abort_q | (abort & (state_q != IDLE));
      unique case (state_q)
         IDLE: begin
            if (go) begin
               cur_nonce_d = nonce_start;
               nonce_end_d = nonce_end;
               zbits_d     = zbits;
               found_d     = 1'b0;
               exhausted_d = 1'b0;
               aborted_d   = 1'b0;
               abort_d     = 1'b0;
               state_d     = LAUNCH;
            end
         end
         LAUNCH: state_d = SERVE;
         SERVE: begin
            // Requests are honoured until s_done even with an abort pending
            if (s_rq && !s_rdy_q) begin
               s_rdy_d  = 1'b1;
               s_data_d = word_sel;
            end
            if (s_done) begin
               hash_d  = s_hash;
               state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = IDLE;
            abort_d = 1'b0;
            if (abort_q || abort) begin
               aborted_d = 1'b1;
            end else if (match) begin
               found_d       = 1'b1;
               found_nonce_d = cur_nonce_q;
            end else if (cur_nonce_q == nonce_end_q) begin
               exhausted_d = 1'b1;
            end else begin
               cur_nonce_d = cur_nonce_q + 32'd1;
               state_d     = LAUNCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         found_q       <= 1'b0;
         exhausted_q   <= 1'b0;
         aborted_q     <= 1'b0;
         abort_q       <= 1'b0;
         s_rdy_q       <= 1'b0;
         found_nonce_q <= '0;
         cur_nonce_q   <= '0;
         nonce_end_q   <= '0;
         s_data_q      <= '0;
         zbits_q       <= '0;
         hash_q        <= '0;
      end else begin
         state_q       <= state_d;
         found_q       <= found_d;
         exhausted_q   <= exhausted_d;
         aborted_q     <= aborted_d;
         abort_q       <= abort_d;
         s_rdy_q       <= s_rdy_d;
         found_nonce_q <= found_nonce_d;
         cur_nonce_q   <= cur_nonce_d;
         nonce_end_q   <= nonce_end_d;
         s_data_q      <= s_data_d;
         zbits_q       <= zbits_d;
         hash_q        <= hash_d;
      end
   end

`ifdef SHA256D_SCHED_COUNT_EN
   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if ((state_q == IDLE) && go) begin
         count_d = '0;
      end else if ((state_q == CHECK) && (count_q != '1)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign hash_count = count_q;
`else
   assign hash_count = '0;
`endif

   assign busy        = (state_q != IDLE);
   assign s_start     = (state_q == LAUNCH);
   assign found       = found_q;
   assign exhausted   = exhausted_q;
   assign aborted     = aborted_q;
   assign found_nonce = found_nonce_q;
   assign cur_nonce   = cur_nonce_q;
   assign s_rdy       = s_rdy_q;
   assign s_data      = s_data_q;

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// tb/tb_sha256d_nonce_scheduler.sv - vector table plus abort and reset sequences against a behavioural core
module tb_sha256d_nonce_scheduler;

   logic         clk, rst_n;
   logic         hdr_we, go, abort;
   logic [6:0]   hdr_addr;
   logic [7:0]   hdr_wdata;
   logic [31:0]  nonce_start, nonce_end;
   logic [8:0]   zbits;
   logic         busy, found, exhausted, aborted;
   logic [31:0]  found_nonce, cur_nonce, hash_count;
   logic         s_start, s_rdy, s_rq, s_done;
   logic [31:0]  s_data;
   logic [4:0]   s_addr;
   logic [255:0] s_hash;

   sha256d_nonce_scheduler #(.HDR_BYTES(76)) dut (
      .clk(clk), .rst_n(rst_n), .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_wdata(hdr_wdata),
      .nonce_start(nonce_start), .nonce_end(nonce_end), .zbits(zbits), .go(go), .abort(abort),
      .busy(busy), .found(found), .exhausted(exhausted), .aborted(aborted),
      .found_nonce(found_nonce), .cur_nonce(cur_nonce), .hash_count(hash_count),
      .s_start(s_start), .s_rdy(s_rdy), .s_data(s_data), .s_addr(s_addr), .s_rq(s_rq),
      .s_hash(s_hash), .s_done(s_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] swap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [31:0] exp_hc(input int n);
`ifdef SHA256D_SCHED_COUNT_EN
      return 32'(n);
`else
      return (n > 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   // Behavioural core: fetches words 0..19 one request at a time, then reports a hash
   int          hash_mode = 0;
   int          cur_served = 0, last_served = 0, total_hashes = 0, core_timeouts = 0;
   logic [31:0] words [20];
   logic [31:0] seen [64];
   logic        alive;
   int          w;
   logic [31:0] core_nonce;

   function automatic logic [255:0] make_hash(input int mode, input logic [31:0] n);
      logic [255:0] h;
      h = '1;
      if (mode == 1 && n == 32'd5) h[255:236] = '0;
      return h;
   endfunction

   initial begin
      s_rq = 1'b0; s_addr = '0; s_done = 1'b0; s_hash = '0;
      forever begin
         @(negedge clk);
         if (rst_n && s_start) begin
            alive = 1'b1;
            cur_served = 0;
            for (int k = 0; k < 20 && alive; k++) begin
               s_addr = 5'(k);
               s_rq = 1'b1;
               w = 0;
               do begin
                  @(negedge clk);
                  w++;
               end while (!s_rdy && w < 10 && rst_n);
               s_rq = 1'b0;
               if (!rst_n) alive = 1'b0;
               else if (!s_rdy) core_timeouts++;
               else begin
                  words[k] = s_data;
                  cur_served++;
               end
            end
            if (alive) begin
               core_nonce = swap(words[19]);
               seen[total_hashes % 64] = core_nonce;
               total_hashes++;
               last_served = cur_served;
               s_hash = make_hash(hash_mode, core_nonce);
               s_done = 1'b1;
               @(negedge clk);
               s_done = 1'b0;
            end
         end
      end
   end

   int total_starts = 0, rdy_gap_err = 0;
   logic prev_rdy = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (s_start) total_starts++;
         if (prev_rdy && s_rdy) rdy_gap_err++;
         prev_rdy = s_rdy;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_sweep(input logic [31:0] ns, input logic [31:0] ne, input logic [8:0] z,
                              input logic we, input logic [6:0] wa, input logic [7:0] wd);
      @(negedge clk);
      nonce_start = ns; nonce_end = ne; zbits = z; go = 1'b1;
      hdr_we = we; hdr_addr = wa; hdr_wdata = wd;
      @(negedge clk);
      go = 1'b0; hdr_we = 1'b0;
      chk("go_to_s_start", s_start, 1'b1);
      chk("busy_after_go", busy, 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("sweep_ended_in_budget", (c < budget), 1'b1);
   endtask

   task automatic wait_served(input int n);
      int c;
      for (c = 0; c < 300; c++) begin
         if (cur_served >= n) break;
         @(negedge clk);
      end
      chk("served_reached", (cur_served >= n), 1'b1);
   endtask

   typedef struct {
      logic [31:0] ns, ne;
      logic [8:0]  z;
      int          mode;
      logic        exp_found, exp_exh;
      logic [31:0] exp_fn, exp_cur;
      int          exp_hashes;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int bs, bh;
      logic seq_ok;
      vecs[0] = '{32'h12345678, 32'h12345678, 9'd0,   0, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 1};
      vecs[1] = '{32'h00000000, 32'h00000002, 9'd256, 0, 1'b0, 1'b1, 32'h12345678, 32'h00000002, 3};
      vecs[2] = '{32'hFFFFFFFE, 32'h00000001, 9'd256, 0, 1'b0, 1'b1, 32'h12345678, 32'h00000001, 4};
      vecs[3] = '{32'h00000000, 32'h0000000A, 9'd20,  1, 1'b1, 1'b0, 32'h00000005, 32'h00000005, 6};
      vecs[4] = '{32'h00000000, 32'h0000000A, 9'd21,  1, 1'b0, 1'b1, 32'h00000005, 32'h0000000A, 11};

      rst_n = 1'b0; hdr_we = 1'b0; hdr_addr = '0; hdr_wdata = '0; go = 1'b0; abort = 1'b0;
      nonce_start = '0; nonce_end = '0; zbits = '0;
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_flags", {found, exhausted, aborted}, 3'b000);
      chk("rst_nonces", {found_nonce, cur_nonce}, 64'h0);
      chk("rst_core_if", {s_start, s_rdy, s_data, hash_count}, 66'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 76; i++) begin
         @(negedge clk);
         hdr_we = 1'b1; hdr_addr = 7'(i); hdr_wdata = 8'(i);
      end
      @(negedge clk);
      hdr_we = 1'b0;

      for (int i = 0; i < 5; i++) begin
         bs = total_starts;
         bh = total_hashes;
         hash_mode = vecs[i].mode;
         start_sweep(vecs[i].ns, vecs[i].ne, vecs[i].z, 1'b0, 7'd0, 8'd0);
         wait_idle(3000);
         repeat (10) @(negedge clk);
         chk($sformatf("v%0d_found", i), found, vecs[i].exp_found);
         chk($sformatf("v%0d_exhausted", i), exhausted, vecs[i].exp_exh);
         chk($sformatf("v%0d_aborted", i), aborted, 1'b0);
         chk($sformatf("v%0d_found_nonce", i), found_nonce, vecs[i].exp_fn);
         chk($sformatf("v%0d_cur_nonce", i), cur_nonce, vecs[i].exp_cur);
         chk($sformatf("v%0d_hash_count", i), hash_count, exp_hc(vecs[i].exp_hashes));
         chk($sformatf("v%0d_start_pulses", i), 32'(total_starts - bs), 32'(vecs[i].exp_hashes));
         seq_ok = (total_hashes - bh) == vecs[i].exp_hashes;
         for (int j = 0; j < total_hashes - bh; j++)
            if (seen[(bh + j) % 64] !== vecs[i].ns + 32'(j)) seq_ok = 1'b0;
         chk($sformatf("v%0d_nonce_sequence", i), seq_ok, 1'b1);
         if (i == 0) begin
            chk("word0", words[0], 32'h00010203);
            chk("word18", words[18], 32'h48494A4B);
            chk("word19", words[19], 32'h78563412);
         end
      end

      // Abort mid-hash; also a header write while busy must be dropped
      bs = total_starts;
      bh = total_hashes;
      hash_mode = 0;
      start_sweep(32'd0, 32'd100, 9'd256, 1'b0, 7'd0, 8'd0);
      @(negedge clk);
      hdr_we = 1'b1; hdr_addr = 7'd0; hdr_wdata = 8'hFF;
      @(negedge clk);
      hdr_we = 1'b0;
      wait_served(7);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle(500);
      repeat (10) @(negedge clk);
      chk("abort_flags", {aborted, found, exhausted}, 3'b100);
      chk("abort_words_served", 32'(last_served), 32'd20);
      chk("abort_done_consumed", 32'(total_hashes - bh), 32'd1);
      chk("abort_start_pulses", 32'(total_starts - bs), 32'd1);
      chk("abort_cur_nonce", cur_nonce, 32'd0);
      chk("abort_hash_count", hash_count, exp_hc(1));

      // Reset while serving, then restart with a same-cycle header write
      start_sweep(32'h50, 32'h60, 9'd256, 1'b0, 7'd0, 8'd0);
      wait_served(3);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_flags", {found, exhausted, aborted}, 3'b000);
      chk("midrst_nonces", {found_nonce, cur_nonce}, 64'h0);
      chk("midrst_core_if", {s_start, s_rdy, s_data, hash_count}, 66'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bh = total_hashes;
      start_sweep(32'd3, 32'd3, 9'd0, 1'b1, 7'd1, 8'h11);
      wait_idle(500);
      repeat (5) @(negedge clk);
      chk("restart_found", {found, exhausted, aborted}, 3'b100);
      chk("restart_found_nonce", found_nonce, 32'd3);
      chk("restart_word0", words[0], 32'h00110203);
      chk("restart_word19", words[19], 32'h03000000);
      chk("restart_hashes", 32'(total_hashes - bh), 32'd1);

      chk("rdy_gap", 32'(rdy_gap_err), 32'd0);
      chk("core_timeouts", 32'(core_timeouts), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
